// File: rtl/group_project_3710.sv
`timescale 1ns/1ps
// group_project_3710 - 16-bit multicycle processor with a unified 256-word
// program/data RAM preloaded with a Fibonacci program. After reset is
// released the program computes F(FIB_N), stores it to RAM word 255 and then
// spins on word 11 forever.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  asynchronous, active-high reset (RAM contents are not cleared)
//
// State | Meaning
// ------+-------------------------------------------------------------
// FETCH | RAM address = PC; edge captures the instruction, PC = PC + 1
// EXEC  | decode/execute the captured instruction; LOAD goes on to MEM
// MEM   | LOAD only: write the registered RAM read data into rd

// group_project_3710_mem - 256 x 16 RAM, synchronous write, registered read.
// Ports:
//   clk, reset  clock / async reset (reset clears only the read register)
//   i_we        write enable, i_addr address, i_wdata write data
//   o_rdata     read data, registered on the clock edge
module group_project_3710_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FIB_N      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [7:0] FIB_IMM = 8'(FIB_N);

  // Power-up image; reset deliberately leaves the array alone so results
  // survive a reset.
  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1] = '{
    0:  16'h4100,               // MOVI r1,0
    1:  16'h4201,               // MOVI r2,1
    2:  {8'h43, FIB_IMM},       // MOVI r3,FIB_N
    3:  16'h45FF,               // MOVI r5,255
    4:  16'h3410,               // MOV  r4,r1
    5:  16'h1420,               // ADD  r4,r2
    6:  16'h3120,               // MOV  r1,r2
    7:  16'h3240,               // MOV  r2,r4
    8:  16'h53FF,               // ADDI r3,-1
    9:  16'h93FA,               // BNZ  r3,-6
    10: 16'h7150,               // STOR r1,[r5]
    11: 16'hA0FF,               // JMP  -1
    default: '0
  };

  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) ram[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rdata <= '0;
    else       r_rdata <= ram[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

module group_project_3710 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FIB_N      = 7
) (
  input  logic clk,
  input  logic reset
);
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2} state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_MOVI = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LOAD = 4'h6;
  localparam logic [3:0] OP_STOR = 4'h7;
  localparam logic [3:0] OP_BNZ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_regs [0:15];
  logic [3:0]            r_ld_rd, w_ld_rd_nxt;

  logic                  w_reg_we;
  logic [3:0]            w_reg_waddr;
  logic [DATA_WIDTH-1:0] w_reg_wdata;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;

  // The RAM read register is the instruction register: the FETCH edge
  // captures ram[PC] into it, and EXEC decodes straight from it.
  logic [3:0]            w_op, w_rd, w_rs;
  logic [7:0]            w_imm;
  logic [DATA_WIDTH-1:0] w_rd_val, w_rs_val, w_imm_zext, w_imm_sext;
  logic [ADDR_WIDTH-1:0] w_pc_rel;

  assign w_op       = w_rdata[15:12];
  assign w_rd       = w_rdata[11:8];
  assign w_rs       = w_rdata[7:4];
  assign w_imm      = w_rdata[7:0];
  assign w_rd_val   = r_regs[w_rd];
  assign w_rs_val   = r_regs[w_rs];
  assign w_imm_zext = {{(DATA_WIDTH-8){1'b0}}, w_imm};
  assign w_imm_sext = {{(DATA_WIDTH-8){w_imm[7]}}, w_imm};
  // Branch target relative to the already-incremented PC, wrapping mod 256.
  assign w_pc_rel   = r_pc + w_imm_sext[ADDR_WIDTH-1:0];

  group_project_3710_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FIB_N      (FIB_N)
  ) mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ld_rd_nxt = r_ld_rd;
    w_reg_we    = 1'b0;
    w_reg_waddr = w_rd;
    w_reg_wdata = '0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_pc;
    w_mem_wdata = w_rd_val;
    case (r_state)
      S_FETCH: begin
        w_pc_nxt    = r_pc + 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        case (w_op)
          OP_ADD:  begin w_reg_we = 1'b1; w_reg_wdata = w_rd_val + w_rs_val;   end
          OP_SUB:  begin w_reg_we = 1'b1; w_reg_wdata = w_rd_val - w_rs_val;   end
          OP_MOV:  begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val;              end
          OP_MOVI: begin w_reg_we = 1'b1; w_reg_wdata = w_imm_zext;            end
          OP_ADDI: begin w_reg_we = 1'b1; w_reg_wdata = w_rd_val + w_imm_sext; end
          OP_LOAD: begin
            w_mem_addr  = w_rs_val[ADDR_WIDTH-1:0];
            w_ld_rd_nxt = w_rd;
            w_state_nxt = S_MEM;
          end
          OP_STOR: begin
            w_mem_we   = 1'b1;
            w_mem_addr = w_rs_val[ADDR_WIDTH-1:0];
          end
          OP_BNZ:  if (w_rd_val != '0) w_pc_nxt = w_pc_rel;
          OP_JMP:  w_pc_nxt = w_pc_rel;
          default: ;
        endcase
      end
      S_MEM: begin
        w_reg_we    = 1'b1;
        w_reg_waddr = r_ld_rd;
        w_reg_wdata = w_rdata;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ld_rd <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ld_rd <= w_ld_rd_nxt;
      if (w_reg_we) r_regs[w_reg_waddr] <= w_reg_wdata;
    end
  end
endmodule

// File: tb/tb_group_project_3710.sv
`timescale 1ns/1ps
module tb_group_project_3710;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst10 = 1'b1;
  always #5 clk = ~clk;

  group_project_3710 dut (.clk(clk), .reset(rst));
  group_project_3710 #(.FIB_N(10)) dut10 (.clk(clk), .reset(rst10));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int writes_seen = 0;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          wcyc;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    int          vcyc;
    int          idx;   // 0..15 register, 16 PC, 17 ram[255], 18 FSM state
    logic [15:0] exp;
  } vec_t;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] peek(input int idx);
    if (idx < 16)       return dut.r_regs[idx];
    else if (idx == 16) return {8'h00, dut.r_pc};
    else if (idx == 17) return dut.mem.ram[255];
    else                return 16'(dut.r_state);
  endfunction

  // RAM write monitor: write enable is stable through EXEC, the write lands
  // on the following rising edge.
  always @(negedge clk) begin
    if (dut.w_mem_we) begin
      wr_t e;
      writes_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h at cycle %0d, expected no write",
                 dut.w_mem_addr, dut.w_mem_wdata, cyc + 1);
      end else begin
        e = sb.pop_front();
        check16("wr_addr", {8'h00, dut.w_mem_addr}, {8'h00, e.addr});
        check16("wr_data", dut.w_mem_wdata, e.data);
        check16("wr_cycle", 16'(cyc + 1), 16'(e.wcyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    logic [15:0] prog [0:11];
    int nz, bad, w0;
    bit found;

    prog = '{16'h4100, 16'h4201, 16'h4307, 16'h45FF, 16'h3410, 16'h1420,
             16'h3120, 16'h3240, 16'h53FF, 16'h93FA, 16'h7150, 16'hA0FF};

    // Edge-by-edge expectations of the first Fibonacci run (edge count from release).
    vt.push_back('{1,  16, 16'd1});
    vt.push_back('{1,  18, 16'd1});
    vt.push_back('{2,  1,  16'd0});
    vt.push_back('{3,  2,  16'd0});
    vt.push_back('{4,  2,  16'd1});
    vt.push_back('{6,  3,  16'd7});
    vt.push_back('{8,  5,  16'h00FF});
    vt.push_back('{10, 4,  16'd0});
    vt.push_back('{12, 4,  16'd1});
    vt.push_back('{14, 1,  16'd1});
    vt.push_back('{16, 2,  16'd1});
    vt.push_back('{18, 3,  16'd6});
    vt.push_back('{20, 16, 16'd4});
    vt.push_back('{24, 4,  16'd2});
    vt.push_back('{30, 3,  16'd5});
    vt.push_back('{92, 16, 16'd10});
    vt.push_back('{93, 17, 16'h0000});
    vt.push_back('{94, 17, 16'h000D});
    vt.push_back('{94, 16, 16'd11});
    vt.push_back('{95, 16, 16'd12});
    vt.push_back('{96, 16, 16'd11});

    // Reset held: nothing moves, nothing written.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check16("rst_pc", peek(16), 16'd0);
    check16("rst_state", peek(18), 16'd0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (peek(i) != 16'd0) nz++;
    check16("rst_regs_nonzero", 16'(nz), 16'd0);
    check16("rst_ram255", peek(17), 16'h0000);
    check16("rst_writes", 16'(writes_seen), 16'd0);

    rst = 1'b0;
    sb.push_back('{8'hFF, 16'h000D, 94});

    foreach (vt[k]) begin
      while (cyc < vt[k].vcyc) begin @(posedge clk); #1; end
      check16($sformatf("vec%0d_c%0d_i%0d", k, vt[k].vcyc, vt[k].idx), peek(vt[k].idx), vt[k].exp);
    end

    while (cyc < 300) begin @(posedge clk); #1; end
    check16("run_r1", peek(1), 16'd13);
    check16("run_r2", peek(2), 16'd21);
    check16("run_r3", peek(3), 16'd0);
    check16("run_r5", peek(5), 16'h00FF);
    check16("run_ram255", peek(17), 16'h000D);
    check16("run_sb_left", 16'(sb.size()), 16'd0);

    // Long spin: PC stays on 11/12, no more writes, program intact.
    bad = 0;
    w0 = writes_seen;
    repeat (10000) begin
      @(posedge clk); #1;
      if (peek(16) != 16'd11 && peek(16) != 16'd12) bad++;
    end
    check16("spin_pc_bad", 16'(bad), 16'd0);
    check16("spin_writes", 16'(writes_seen - w0), 16'd0);
    check16("spin_ram255", peek(17), 16'h000D);
    nz = 0;
    for (int i = 0; i < 12; i++) if (dut.mem.ram[i] !== prog[i]) nz++;
    check16("prog_intact_diffs", 16'(nz), 16'd0);

    // Async reset between edges in the middle of the loop, then rerun.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back('{8'hFF, 16'h000D, 94});
    while (cyc < 40) begin @(posedge clk); #1; end
    check16("mid_r3", peek(3), 16'd5);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    nz = 0;
    for (int i = 0; i < 16; i++) if (peek(i) != 16'd0) nz++;
    check16("async_regs_nonzero", 16'(nz), 16'd0);
    check16("async_pc", peek(16), 16'd0);
    check16("async_state", peek(18), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back('{8'hFF, 16'h000D, 94});
    while (cyc < 200) begin @(posedge clk); #1; end
    check16("rerun_sb_left", 16'(sb.size()), 16'd0);
    check16("rerun_ram255", peek(17), 16'h000D);
    check16("rerun_r1", peek(1), 16'd13);

    // FIB_N = 10 build.
    rst10 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge clk); #1;
      if (dut10.mem.ram[255] == 16'h0037) found = 1'b1;
    end
    check16("fib10_found", {15'd0, found}, 16'd1);
    check16("fib10_ram255", dut10.mem.ram[255], 16'h0037);
    check16("fib10_r2", dut10.r_regs[2], 16'd89);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
